// File: rtl/dot_acc_npairs_if.sv
// dot_acc_npairs_if: beat-in / result-out handshake bundle for dot_acc_npairs.
//
// Signals (names are those of the original flat port list):
//   dot_acc_in_valid_i   input beat valid
//   dot_acc_in_ready_o   engine accepts a beat this cycle
//   dot_acc_in_last_i    beat closes the current vector
//   dot_acc_in_a_i       operand A per pair, signed
//   dot_acc_in_b_i       operand B per pair, signed
//   dot_acc_out_valid_o  result valid
//   dot_acc_out_ready_i  downstream takes the result
//   dot_acc_out_data_o   signed dot product
//   dot_acc_out_beats_o  beats in the vector (modulo 2^CNT_WIDTH)
//   dot_acc_out_sat_o    result was clamped
//
// Modports: master = producer/consumer side, slave = the engine.
// Parameters must match those of the dot_acc_npairs instance using it.
interface dot_acc_npairs_if #(
  parameter int unsigned N_PAIRS       = 4,
  parameter int unsigned OPERAND_WIDTH = 8,
  parameter int unsigned OUT_WIDTH     = 2 * OPERAND_WIDTH,
  parameter int unsigned CNT_WIDTH     = 10
);

  logic                                    dot_acc_in_valid_i;
  logic                                    dot_acc_in_ready_o;
  logic                                    dot_acc_in_last_i;
  logic [N_PAIRS-1:0][OPERAND_WIDTH-1:0]   dot_acc_in_a_i;
  logic [N_PAIRS-1:0][OPERAND_WIDTH-1:0]   dot_acc_in_b_i;
  logic                                    dot_acc_out_valid_o;
  logic                                    dot_acc_out_ready_i;
  logic [OUT_WIDTH-1:0]                    dot_acc_out_data_o;
  logic [CNT_WIDTH-1:0]                    dot_acc_out_beats_o;
  logic                                    dot_acc_out_sat_o;

  modport master (
    output dot_acc_in_valid_i,
    output dot_acc_in_last_i,
    output dot_acc_in_a_i,
    output dot_acc_in_b_i,
    output dot_acc_out_ready_i,
    input  dot_acc_in_ready_o,
    input  dot_acc_out_valid_o,
    input  dot_acc_out_data_o,
    input  dot_acc_out_beats_o,
    input  dot_acc_out_sat_o
  );

  modport slave (
    input  dot_acc_in_valid_i,
    input  dot_acc_in_last_i,
    input  dot_acc_in_a_i,
    input  dot_acc_in_b_i,
    input  dot_acc_out_ready_i,
    output dot_acc_in_ready_o,
    output dot_acc_out_valid_o,
    output dot_acc_out_data_o,
    output dot_acc_out_beats_o,
    output dot_acc_out_sat_o
  );

endinterface

// File: rtl/dot_acc_npairs.sv
// dot_acc_npairs: pipelined multi-pair multiply-accumulate engine.
//
// Each accepted beat carries N_PAIRS signed operand pairs. Products are
// registered (P1), summed and registered (P2), then accumulated across beats
// until a beat flagged last; one signed result per vector is then held on a
// valid/ready output with full backpressure.
//
// Ports:
//   dot_acc_clk  clock, rising edge
//   dot_acc_rst  synchronous active-high reset
//   bus          dot_acc_npairs_if.slave (beat input and result output)
//
// Optional feature macro: DOT_ACC_SAT_EN
//   defined   : result clamped to the signed OUT_WIDTH range, out_sat flags it
//   undefined : result is the low OUT_WIDTH accumulator bits, out_sat = 0
//
// N_PAIRS must be >= 1 and OUT_WIDTH <= ACC_WIDTH.
module dot_acc_npairs #(
  parameter int unsigned N_PAIRS       = 4,
  parameter int unsigned OPERAND_WIDTH = 8,
  parameter int unsigned ACC_WIDTH     = 2 * OPERAND_WIDTH + $clog2(N_PAIRS) + 8,
  parameter int unsigned OUT_WIDTH     = 2 * OPERAND_WIDTH,
  parameter int unsigned CNT_WIDTH     = 10
) (
  input  logic            dot_acc_clk,
  input  logic            dot_acc_rst,
  dot_acc_npairs_if.slave bus
);

  localparam int unsigned PROD_W = 2 * OPERAND_WIDTH;
  localparam int unsigned SUM_W  = PROD_W + $clog2(N_PAIRS);

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_e;

  state_e                      state_q, state_d;

  logic signed [PROD_W-1:0]    p1_prod_q [N_PAIRS];
  logic signed [PROD_W-1:0]    p1_prod_d [N_PAIRS];
  logic                        p1_valid_q, p1_valid_d;
  logic                        p1_last_q, p1_last_d;

  logic signed [SUM_W-1:0]     p2_sum_q, p2_sum_d;
  logic                        p2_valid_q, p2_valid_d;
  logic                        p2_last_q, p2_last_d;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]        beats_q, beats_d;

  logic                        out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]        out_beats_q, out_beats_d;
  logic                        out_sat_q, out_sat_d;

  logic                        stall;
  logic                        load_out;
  logic signed [ACC_WIDTH-1:0] sum_ext;
  logic signed [ACC_WIDTH-1:0] acc_fin;
  logic [CNT_WIDTH-1:0]        beats_fin;
  logic [OUT_WIDTH-1:0]        res_data;
  logic                        res_sat;
`ifdef DOT_ACC_SAT_EN
  logic [ACC_WIDTH-OUT_WIDTH:0] hi_bits;
`endif

  // A held result that downstream refuses freezes the whole pipe, so the
  // input is refused on exactly those cycles and no beat is lost.
  always_comb begin
    stall = out_valid_q & ~bus.dot_acc_out_ready_i;
  end

  // P1: per-pair signed products.
  always_comb begin
    p1_valid_d = p1_valid_q;
    p1_last_d  = p1_last_q;
    for (int unsigned i = 0; i < N_PAIRS; i++) begin
      p1_prod_d[i] = p1_prod_q[i];
    end
    if (!stall) begin
      p1_valid_d = bus.dot_acc_in_valid_i;
      p1_last_d  = bus.dot_acc_in_last_i;
      for (int unsigned i = 0; i < N_PAIRS; i++) begin
        p1_prod_d[i] = PROD_W'($signed(bus.dot_acc_in_a_i[i]))
                     * PROD_W'($signed(bus.dot_acc_in_b_i[i]));
      end
    end
  end

  // P2: sign-extended sum of all products of the beat.
  always_comb begin
    p2_valid_d = p2_valid_q;
    p2_last_d  = p2_last_q;
    p2_sum_d   = p2_sum_q;
    if (!stall) begin
      p2_valid_d = p1_valid_q;
      p2_last_d  = p1_last_q;
      p2_sum_d   = '0;
      for (int unsigned i = 0; i < N_PAIRS; i++) begin
        p2_sum_d = p2_sum_d + SUM_W'(p1_prod_q[i]);
      end
    end
  end

  // Stage 3: the first beat of a vector loads, later beats add; the value
  // that goes into the accumulator is also the one a last beat publishes.
  always_comb begin
    sum_ext   = ACC_WIDTH'(p2_sum_q);
    acc_fin   = (state_q == S_ACCUM) ? (acc_q + sum_ext) : sum_ext;
    beats_fin = (state_q == S_ACCUM) ? (beats_q + CNT_WIDTH'(1)) : CNT_WIDTH'(1);

`ifdef DOT_ACC_SAT_EN
    // In range when every bit from the OUT_WIDTH sign bit upward agrees.
    hi_bits = acc_fin[ACC_WIDTH-1:OUT_WIDTH-1];
    if ((&hi_bits) || (~|hi_bits)) begin
      res_data = acc_fin[OUT_WIDTH-1:0];
      res_sat  = 1'b0;
    end else if (acc_fin[ACC_WIDTH-1]) begin
      res_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      res_sat  = 1'b1;
    end else begin
      res_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      res_sat  = 1'b1;
    end
`else
    res_data = acc_fin[OUT_WIDTH-1:0];
    res_sat  = 1'b0;
`endif

    state_d  = state_q;
    acc_d    = acc_q;
    beats_d  = beats_q;
    load_out = 1'b0;
    if (!stall && p2_valid_q) begin
      acc_d   = acc_fin;
      beats_d = beats_fin;
      if (p2_last_q) begin
        state_d  = S_IDLE;
        load_out = 1'b1;
      end else begin
        state_d  = S_ACCUM;
      end
    end
  end

  // Output register: a new result may replace one being taken on the same edge.
  always_comb begin
    out_valid_d = out_valid_q & ~bus.dot_acc_out_ready_i;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    out_sat_d   = out_sat_q;
    if (load_out) begin
      out_valid_d = 1'b1;
      out_data_d  = res_data;
      out_beats_d = beats_fin;
      out_sat_d   = res_sat;
    end
  end

  always_ff @(posedge dot_acc_clk) begin
    if (dot_acc_rst) begin
      state_q     <= S_IDLE;
      p1_valid_q  <= 1'b0;
      p1_last_q   <= 1'b0;
      for (int unsigned i = 0; i < N_PAIRS; i++) begin
        p1_prod_q[i] <= '0;
      end
      p2_valid_q  <= 1'b0;
      p2_last_q   <= 1'b0;
      p2_sum_q    <= '0;
      acc_q       <= '0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1_valid_q  <= p1_valid_d;
      p1_last_q   <= p1_last_d;
      for (int unsigned i = 0; i < N_PAIRS; i++) begin
        p1_prod_q[i] <= p1_prod_d[i];
      end
      p2_valid_q  <= p2_valid_d;
      p2_last_q   <= p2_last_d;
      p2_sum_q    <= p2_sum_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.dot_acc_in_ready_o  = ~stall;
  assign bus.dot_acc_out_valid_o = out_valid_q;
  assign bus.dot_acc_out_data_o  = out_data_q;
  assign bus.dot_acc_out_beats_o = out_beats_q;
  assign bus.dot_acc_out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_dot_acc_npairs.sv
// tb_dot_acc_npairs: two engines fed the same beats -- A with OUT_WIDTH=16,
// CNT_WIDTH=10 and B with OUT_WIDTH=24, CNT_WIDTH=4 -- checked against an
// arithmetic reference (exact dot product, then wrap/clamp rules).
module tb_dot_acc_npairs;

  localparam int NP    = 4;
  localparam int OPW   = 8;
  localparam int ACC_W = 2 * OPW + $clog2(NP) + 8;
  localparam int OUTA  = 16;
  localparam int CNTA  = 10;
  localparam int OUTB  = 24;
  localparam int CNTB  = 4;

  typedef logic [NP-1:0][OPW-1:0] vec_t;
  typedef struct {
    longint data;
    longint beats;
    longint sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_last, out_ready;
  vec_t in_a, in_b;

  int total = 0;
  int bad   = 0;

  exp_t   qa[$];
  exp_t   qb[$];
  longint mfull  = 0;
  longint mbeats = 0;

  always #5 clk = ~clk;

  dot_acc_npairs_if #(.N_PAIRS(NP), .OPERAND_WIDTH(OPW), .OUT_WIDTH(OUTA), .CNT_WIDTH(CNTA)) ia ();
  dot_acc_npairs_if #(.N_PAIRS(NP), .OPERAND_WIDTH(OPW), .OUT_WIDTH(OUTB), .CNT_WIDTH(CNTB)) ib ();

  assign ia.dot_acc_in_valid_i  = in_valid;
  assign ia.dot_acc_in_last_i   = in_last;
  assign ia.dot_acc_in_a_i      = in_a;
  assign ia.dot_acc_in_b_i      = in_b;
  assign ia.dot_acc_out_ready_i = out_ready;
  assign ib.dot_acc_in_valid_i  = in_valid;
  assign ib.dot_acc_in_last_i   = in_last;
  assign ib.dot_acc_in_a_i      = in_a;
  assign ib.dot_acc_in_b_i      = in_b;
  assign ib.dot_acc_out_ready_i = out_ready;

  dot_acc_npairs #(.N_PAIRS(NP), .OPERAND_WIDTH(OPW), .OUT_WIDTH(OUTA), .CNT_WIDTH(CNTA)) u_a (
    .dot_acc_clk (clk),
    .dot_acc_rst (rst),
    .bus         (ia.slave)
  );

  dot_acc_npairs #(.N_PAIRS(NP), .OPERAND_WIDTH(OPW), .OUT_WIDTH(OUTB), .CNT_WIDTH(CNTB)) u_b (
    .dot_acc_clk (clk),
    .dot_acc_rst (rst),
    .bus         (ib.slave)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Exact dot product -> wrap at ACC_W -> clamp or wrap to outw; beats mod 2^cntw.
  function automatic exp_t mk_exp(input longint full, input longint nb, input int outw, input int cntw);
    exp_t   e;
    longint m, hi, lo, span;
    m = full & ((64'sd1 <<< ACC_W) - 1);
    if (m >= (64'sd1 <<< (ACC_W - 1))) m = m - (64'sd1 <<< ACC_W);
    hi   = (64'sd1 <<< (outw - 1)) - 1;
    lo   = -(64'sd1 <<< (outw - 1));
    span = 64'sd1 <<< outw;
`ifdef DOT_ACC_SAT_EN
    if (m > hi) begin
      e.data = hi; e.sat = 1;
    end else if (m < lo) begin
      e.data = lo; e.sat = 1;
    end else begin
      e.data = m;  e.sat = 0;
    end
`else
    e.data = m & (span - 1);
    if (e.data > hi) e.data = e.data - span;
    e.sat = 0;
`endif
    e.beats = nb % (64'sd1 <<< cntw);
    return e;
  endfunction

  // Results are compared on the negedge before the edge that transfers them.
  always @(negedge clk) begin
    if (!rst && ia.dot_acc_out_valid_o && out_ready) begin
      if (qa.size() == 0) begin
        check("a_unexpected_out", longint'(ia.dot_acc_out_valid_o), 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_data",  longint'($signed(ia.dot_acc_out_data_o)), e.data);
        check("a_beats", longint'(ia.dot_acc_out_beats_o), e.beats);
        check("a_sat",   longint'(ia.dot_acc_out_sat_o), e.sat);
      end
    end
    if (!rst && ib.dot_acc_out_valid_o && out_ready) begin
      if (qb.size() == 0) begin
        check("b_unexpected_out", longint'(ib.dot_acc_out_valid_o), 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_data",  longint'($signed(ib.dot_acc_out_data_o)), e.data);
        check("b_beats", longint'(ib.dot_acc_out_beats_o), e.beats);
        check("b_sat",   longint'(ib.dot_acc_out_sat_o), e.sat);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input vec_t a, input vec_t b, input bit last);
    bit rdy;
    bit acc = 1'b0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      rdy = ia.dot_acc_in_ready_o;
      @(posedge clk);
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("beat_accepted", longint'(acc), 1);
    if (acc) begin
      for (int i = 0; i < NP; i++) begin
        mfull = mfull + longint'($signed(a[i])) * longint'($signed(b[i]));
      end
      mbeats++;
      if (last) begin
        qa.push_back(mk_exp(mfull, mbeats, OUTA, CNTA));
        qb.push_back(mk_exp(mfull, mbeats, OUTB, CNTB));
        mfull  = 0;
        mbeats = 0;
      end
    end
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (ia.dot_acc_out_valid_o !== 1'b1 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("out_valid_seen", longint'(ia.dot_acc_out_valid_o), 1);
  endtask

  task automatic drain();
    int k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("drain_a_left", longint'(qa.size()), 0);
    check("drain_b_left", longint'(qb.size()), 0);
  endtask

  task automatic fill(output vec_t v, input int x);
    v = '0;
    for (int i = 0; i < NP; i++) v[i] = OPW'(x);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, vb;
    int   lat;
    bit   saw_low;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_in_ready",  longint'(ia.dot_acc_in_ready_o), 1);
    check("rst_out_valid", longint'(ia.dot_acc_out_valid_o), 0);
    check("rst_out_data",  longint'(ia.dot_acc_out_data_o), 0);
    check("rst_out_beats", longint'(ia.dot_acc_out_beats_o), 0);
    check("rst_out_sat",   longint'(ia.dot_acc_out_sat_o), 0);
    check("rst_b_valid",   longint'(ib.dot_acc_out_valid_o), 0);
    @(posedge clk); #1;

    // {1,2,3,4}.{5,6,7,8} = 70; valid after the accept edge and two more.
    va = '0; vb = '0;
    for (int i = 0; i < NP; i++) begin
      va[i] = OPW'(i + 1);
      vb[i] = OPW'(i + 5);
    end
    send_beat(va, vb, 1'b1);
    lat = 1;
    while (ia.dot_acc_out_valid_o !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency_edges", longint'(lat), 3);
    check("t1_data",  longint'($signed(ia.dot_acc_out_data_o)), 70);
    check("t1_beats", longint'(ia.dot_acc_out_beats_o), 1);
    check("t1_sat",   longint'(ia.dot_acc_out_sat_o), 0);
    drain();

    // Three beats of (-128)*(-128)*4 = 65536 each.
    fill(va, -128); fill(vb, -128);
    send_beat(va, vb, 1'b0);
    send_beat(va, vb, 1'b0);
    send_beat(va, vb, 1'b1);
    wait_out(lat);
    check("t2_b_data",  longint'($signed(ib.dot_acc_out_data_o)), 196608);
    check("t2_b_beats", longint'(ib.dot_acc_out_beats_o), 3);
`ifdef DOT_ACC_SAT_EN
    check("t2_a_data", longint'($signed(ia.dot_acc_out_data_o)), 32767);
    check("t2_a_sat",  longint'(ia.dot_acc_out_sat_o), 1);
`else
    check("t2_a_data", longint'($signed(ia.dot_acc_out_data_o)), 0);
    check("t2_a_sat",  longint'(ia.dot_acc_out_sat_o), 0);
`endif
    drain();

    // 4 * 127 * 127 = 64516.
    fill(va, 127); fill(vb, 127);
    send_beat(va, vb, 1'b1);
    wait_out(lat);
    check("t3_b_data", longint'($signed(ib.dot_acc_out_data_o)), 64516);
`ifdef DOT_ACC_SAT_EN
    check("t3_a_data", longint'($signed(ia.dot_acc_out_data_o)), 32767);
    check("t3_a_sat",  longint'(ia.dot_acc_out_sat_o), 1);
`else
    check("t3_a_data", longint'($signed(ia.dot_acc_out_data_o)), -1020);
    check("t3_a_sat",  longint'(ia.dot_acc_out_sat_o), 0);
`endif
    drain();

    // Backpressure: out_ready low for 5 cycles during back-to-back vectors.
    saw_low   = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (!ia.dot_acc_in_ready_o) saw_low = 1'b1;
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
      begin
        for (int v = 0; v < 6; v++) begin
          for (int i = 0; i < NP; i++) begin
            va[i] = OPW'($urandom);
            vb[i] = OPW'($urandom);
          end
          send_beat(va, vb, 1'b1);
        end
      end
    join
    check("stall_in_ready_low", longint'(saw_low), 1);
    drain();

    // Reset after 2 of 4 beats: nothing may come out.
    fill(va, 50); fill(vb, 50);
    send_beat(va, vb, 1'b0);
    send_beat(va, vb, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mfull = 0; mbeats = 0;
    qa.delete(); qb.delete();
    repeat (6) begin
      @(negedge clk);
      check("post_rst_a_valid", longint'(ia.dot_acc_out_valid_o), 0);
      check("post_rst_b_valid", longint'(ib.dot_acc_out_valid_o), 0);
    end
    @(posedge clk); #1;
    va = '0; vb = '0;
    va[0] = OPW'(1); vb[0] = OPW'(-3);
    send_beat(va, vb, 1'b1);
    wait_out(lat);
    check("t5_data",  longint'($signed(ia.dot_acc_out_data_o)), -3);
    check("t5_beats", longint'(ia.dot_acc_out_beats_o), 1);
    drain();

    // 18 beats of 1*1: B's 4-bit beat counter wraps to 2.
    va = '0; vb = '0;
    va[0] = OPW'(1); vb[0] = OPW'(1);
    for (int j = 0; j < 18; j++) send_beat(va, vb, j == 17);
    wait_out(lat);
    check("t6_a_data",  longint'($signed(ia.dot_acc_out_data_o)), 18);
    check("t6_a_beats", longint'(ia.dot_acc_out_beats_o), 18);
    check("t6_b_data",  longint'($signed(ib.dot_acc_out_data_o)), 18);
    check("t6_b_beats", longint'(ib.dot_acc_out_beats_o), 2);
    drain();

    // Random vectors with random gaps and random downstream readiness.
    begin
      bit rand_done = 1'b0;
      fork
        begin
          while (!rand_done) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 9) < 7);
          end
        end
        begin
          for (int v = 0; v < 30; v++) begin
            int unsigned nb;
            nb = $urandom_range(1, 5);
            for (int unsigned j = 0; j < nb; j++) begin
              for (int i = 0; i < NP; i++) begin
                va[i] = OPW'($urandom);
                vb[i] = OPW'($urandom);
              end
              send_beat(va, vb, j == nb - 1);
              if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
              end
            end
          end
          rand_done = 1'b1;
        end
      join
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
